// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the sisc instruction sequencer.
//   - Opcode constants for the sisc instruction set (opcode = top 4 bits of IR).
//   - Sequencer state encoding.
//   - opcode_of(): extracts the opcode from an instruction word of any width
//     up to IR_MAX bits.
package sisc_pkg;

  localparam int IR_MAX = 64;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_ALUI = 4'h9;  // ALU form with the immediate bit set
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_WAIT = 2'd1,
    RUN      = 2'd2,
    STOP     = 2'd3
  } seq_state_t;

  // Caller zero-extends its word to IR_MAX bits and passes its real width,
  // so the opcode is always taken from the top nibble of the real word.
  function automatic logic [3:0] opcode_of(input logic [IR_MAX-1:0] word,
                                           input int              w);
    return 4'(word >> (w - 4));
  endfunction

endpackage

// File: rtl/sisc_prog_mem.sv
// sisc_prog_mem: program store for the sisc sequencer.
//   DEPTH x IR_W words, synchronous write, asynchronous read. Not reset.
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module sisc_prog_mem
  import sisc_pkg::*;
#(
  parameter int IR_W  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [IR_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [IR_W-1:0] rdata
);

  logic [IR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sisc_ir_sequencer.sv
// sisc_ir_sequencer: loadable instruction feeder for the sisc core.
//   After start it holds cpu_rst_f low for RST_CYCLES clocks, then presents
//   one program word on ir every HOLD_CYCLES clocks, stopping on an HLT
//   opcode, at the end of the program, or wrapping when loop_mode is set.
// Optional feature: define SISC_SEQ_RETIRE_CNT_EN to add the 32-bit
//   saturating 'retired' counter output.
// Ports:
//   CLK, RST_F          - clock (rising edge), synchronous active-low reset
//   ld_en/ld_addr/ld_data - program write port (honoured in IDLE/STOP only)
//   start, abort        - run control
//   loop_mode           - wrap to word 0 after the last word
//   cpu_rst_f           - active-low reset to the core
//   ir, ir_valid, pc    - presented instruction, its validity and address
//   halted, done        - stopped on HLT / stopped at end of program
//   retired             - completed-instruction count (optional)
module sisc_ir_sequencer
  import sisc_pkg::*;
#(
  parameter int IR_W        = 32,
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int HOLD_CYCLES = 10,
  parameter int RST_CYCLES  = 2
) (
  input  logic            CLK,
  input  logic            RST_F,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [IR_W-1:0] ld_data,
  input  logic            start,
  input  logic            abort,
  input  logic            loop_mode,
  output logic            cpu_rst_f,
  output logic [IR_W-1:0] ir,
  output logic            ir_valid,
  output logic [AW-1:0]   pc,
  output logic            halted,
`ifdef SISC_SEQ_RETIRE_CNT_EN
  output logic            done,
  output logic [31:0]     retired
`else
  output logic            done
`endif
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

  seq_state_t      state, state_nxt;
  logic [AW-1:0]   pc_nxt, rd_addr;
  logic [IR_W-1:0] ir_nxt, rd_data;
  logic            ir_valid_nxt, cpu_rst_f_nxt, halted_nxt, done_nxt;
  logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
  logic [RW-1:0]   rst_cnt, rst_cnt_nxt;
  logic            mem_we;
`ifdef SISC_SEQ_RETIRE_CNT_EN
  logic [31:0]     retired_nxt;
`endif

  assign mem_we = ld_en && ((state == IDLE) || (state == STOP));

  // Read address is the pc the next word will be presented at: word 0 when
  // leaving RST_WAIT or wrapping, otherwise pc+1 while running.
  always_comb begin
    rd_addr = '0;
    if ((state == RUN) && (pc != PC_LAST)) rd_addr = pc + AW'(1);
  end

  sisc_prog_mem #(
    .IR_W  (IR_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST_F) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      cpu_rst_f <= 1'b0;
      halted    <= 1'b0;
      done      <= 1'b0;
      hold_cnt  <= '0;
      rst_cnt   <= '0;
`ifdef SISC_SEQ_RETIRE_CNT_EN
      retired   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      cpu_rst_f <= cpu_rst_f_nxt;
      halted    <= halted_nxt;
      done      <= done_nxt;
      hold_cnt  <= hold_cnt_nxt;
      rst_cnt   <= rst_cnt_nxt;
`ifdef SISC_SEQ_RETIRE_CNT_EN
      retired   <= retired_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;
    cpu_rst_f_nxt = cpu_rst_f;
    halted_nxt    = halted;
    done_nxt      = done;
    hold_cnt_nxt  = hold_cnt;
    rst_cnt_nxt   = rst_cnt;
`ifdef SISC_SEQ_RETIRE_CNT_EN
    retired_nxt   = retired;
`endif
    case (state)
      IDLE, STOP: begin
        if (start) begin
          state_nxt     = RST_WAIT;
          cpu_rst_f_nxt = 1'b0;
          pc_nxt        = '0;
          halted_nxt    = 1'b0;
          done_nxt      = 1'b0;
          ir_nxt        = '0;
          ir_valid_nxt  = 1'b0;
          rst_cnt_nxt   = '0;
`ifdef SISC_SEQ_RETIRE_CNT_EN
          retired_nxt   = '0;
`endif
        end
      end
      RST_WAIT, RUN: begin
        // abort wins over any end-of-hold or end-of-reset transition
        if (abort) begin
          state_nxt     = IDLE;
          ir_nxt        = '0;
          ir_valid_nxt  = 1'b0;
          cpu_rst_f_nxt = 1'b0;
          pc_nxt        = '0;
          hold_cnt_nxt  = '0;
          rst_cnt_nxt   = '0;
        end else if (state == RST_WAIT) begin
          if (rst_cnt == RST_LAST) begin
            state_nxt     = RUN;
            cpu_rst_f_nxt = 1'b1;
            ir_nxt        = rd_data;
            ir_valid_nxt  = 1'b1;
            hold_cnt_nxt  = '0;
          end else begin
            rst_cnt_nxt = rst_cnt + RW'(1);
          end
        end else if (hold_cnt == HOLD_LAST) begin
`ifdef SISC_SEQ_RETIRE_CNT_EN
          if (retired != '1) retired_nxt = retired + 32'd1;
`endif
          if (opcode_of(IR_MAX'(ir), IR_W) == OP_HLT) begin
            state_nxt    = STOP;
            halted_nxt   = 1'b1;
            ir_valid_nxt = 1'b0;
          end else if ((pc == PC_LAST) && loop_mode) begin
            pc_nxt       = '0;
            ir_nxt       = rd_data;
            hold_cnt_nxt = '0;
          end else if (pc == PC_LAST) begin
            state_nxt    = STOP;
            done_nxt     = 1'b1;
            ir_nxt       = '0;
            ir_valid_nxt = 1'b0;
          end else begin
            pc_nxt       = pc + AW'(1);
            ir_nxt       = rd_data;
            hold_cnt_nxt = '0;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sisc_ir_sequencer.sv
// tb_sisc_ir_sequencer: self-checking bench for sisc_ir_sequencer.
//   Table of single-cycle vectors for reset/load/idle behaviour, then
//   multi-cycle runs whose per-clock expected outputs are queued when the
//   stimulus is driven and popped one per clock after each rising edge.
module tb_sisc_ir_sequencer;

  localparam int IR_W  = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HOLD  = 10;
  localparam int RSTC  = 2;

  logic            CLK = 1'b0;
  logic            RST_F, ld_en, start, abort, loop_mode;
  logic [AW-1:0]   ld_addr;
  logic [IR_W-1:0] ld_data;
  logic            cpu_rst_f, ir_valid, halted, done;
  logic [IR_W-1:0] ir;
  logic [AW-1:0]   pc;
`ifdef SISC_SEQ_RETIRE_CNT_EN
  logic [31:0]     retired;
`endif

  always #5 CLK = ~CLK;

  sisc_ir_sequencer #(
    .IR_W        (IR_W),
    .DEPTH       (DEPTH),
    .AW          (AW),
    .HOLD_CYCLES (HOLD),
    .RST_CYCLES  (RSTC)
  ) dut (
    .CLK       (CLK),
    .RST_F     (RST_F),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .abort     (abort),
    .loop_mode (loop_mode),
    .cpu_rst_f (cpu_rst_f),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .halted    (halted),
`ifdef SISC_SEQ_RETIRE_CNT_EN
    .done      (done),
    .retired   (retired)
`else
    .done      (done)
`endif
  );

  typedef struct packed {
    logic            crf;
    logic [IR_W-1:0] ir;
    logic            iv;
    logic [AW-1:0]   pc;
    logic            hlt;
    logic            dn;
  } obs_t;

  typedef struct {
    logic            rf;
    logic            le;
    logic [AW-1:0]   la;
    logic [IR_W-1:0] ld;
    logic            ab;
    obs_t            e;
  } vec_t;

  int              errors = 0;
  int              checks = 0;
  obs_t            sb[$];
  string           nm[$];
  logic [IR_W-1:0] exp_mem [DEPTH];
  vec_t            tbl [6];

  function automatic obs_t mk(input logic crf, input logic [IR_W-1:0] i,
                              input logic iv, input logic [AW-1:0] p,
                              input logic h, input logic d);
    obs_t o;
    o.crf = crf; o.ir = i; o.iv = iv; o.pc = p; o.hlt = h; o.dn = d;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t e);
    obs_t a;
    a = mk(cpu_rst_f, ir, ir_valid, pc, halted, done);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got crf=%b ir=%h iv=%b pc=%0d hlt=%b dn=%b, want crf=%b ir=%h iv=%b pc=%0d hlt=%b dn=%b",
               name, a.crf, a.ir, a.iv, a.pc, a.hlt, a.dn,
               e.crf, e.ir, e.iv, e.pc, e.hlt, e.dn);
    end
  endtask

`ifdef SISC_SEQ_RETIRE_CNT_EN
  task automatic check_retired(input string name, input logic [31:0] want);
    checks++;
    if (retired !== want) begin
      errors++;
      $display("FAIL %s: got retired=%0d, want %0d", name, retired, want);
    end
  endtask
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string n, input obs_t e);
    sb.push_back(e);
    nm.push_back(n);
  endtask

  task automatic push_rst();
    for (int i = 0; i < RSTC; i++) push("rst_wait", mk(1'b0, '0, 1'b0, '0, 1'b0, 1'b0));
  endtask

  // 'count' words starting at 'first', each for its full hold period
  task automatic push_words(input int first, input int count, input int holds);
    for (int k = 0; k < count; k++) begin
      int p;
      p = (first + k) % DEPTH;
      for (int h = 0; h < ((k == count - 1) ? holds : HOLD); h++)
        push($sformatf("run_pc%0d_h%0d", p, h), mk(1'b1, exp_mem[p], 1'b1, AW'(p), 1'b0, 1'b0));
    end
  endtask

  task automatic step_check();
    obs_t  e;
    string n;
    tick();
    e = sb.pop_front();
    n = nm.pop_front();
    compare(n, e);
  endtask

  task automatic drain();
    while (sb.size() != 0) step_check();
  endtask

  task automatic load(input int a, input logic [IR_W-1:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    tick();
    ld_en = 1'b0;
    exp_mem[a] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t idle_o;
    idle_o = mk(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    RST_F = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

    // reset, load mem[0..2], abort while idle: outputs stay at reset values
    tbl[0] = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b0, idle_o};
    tbl[1] = '{1'b0, 1'b1, 4'd7, 32'h1234_5678, 1'b0, idle_o};
    tbl[2] = '{1'b1, 1'b1, 4'd0, 32'h0000_0000, 1'b0, idle_o};
    tbl[3] = '{1'b1, 1'b1, 4'd1, 32'h8012_3001, 1'b0, idle_o};
    tbl[4] = '{1'b1, 1'b1, 4'd2, 32'hF023_0000, 1'b0, idle_o};
    tbl[5] = '{1'b1, 1'b0, 4'd0, 32'h0,        1'b1, idle_o};
    for (int i = 0; i < 6; i++) begin
      RST_F = tbl[i].rf; ld_en = tbl[i].le; ld_addr = tbl[i].la;
      ld_data = tbl[i].ld; abort = tbl[i].ab;
      tick();
      if (tbl[i].rf && tbl[i].le) exp_mem[tbl[i].la] = tbl[i].ld;
      compare($sformatf("vec%0d", i), tbl[i].e);
    end
    ld_en = 1'b0; abort = 1'b0;
`ifdef SISC_SEQ_RETIRE_CNT_EN
    check_retired("retired_reset", 32'd0);
`endif

    // three-word program ending in HLT
    start = 1'b1;
    push_rst();
    push_words(0, 3, HOLD);
    for (int i = 0; i < 3; i++) push("halted", mk(1'b1, 32'hF023_0000, 1'b0, 4'd2, 1'b1, 1'b0));
    step_check();
    start = 1'b0;
    drain();
`ifdef SISC_SEQ_RETIRE_CNT_EN
    check_retired("retired_hlt", 32'd3);
`endif

    // reload all 16 words with ADD while stopped; run to end without loop
    for (int a = 0; a < DEPTH; a++) load(a, 32'h8012_3001);
    compare("stop_during_load", mk(1'b1, 32'hF023_0000, 1'b0, 4'd2, 1'b1, 1'b0));
    start = 1'b1;
    push_rst();
    push_words(0, DEPTH, HOLD);
    for (int i = 0; i < 3; i++) push("done", mk(1'b1, '0, 1'b0, 4'd15, 1'b0, 1'b1));
    step_check();
    start = 1'b0;
    drain();
`ifdef SISC_SEQ_RETIRE_CNT_EN
    check_retired("retired_done", 32'd16);
`endif

    // loop mode: wrap, then abort on the last hold clock of pc=3
    loop_mode = 1'b1;
    start = 1'b1;
    push_rst();
    push_words(0, DEPTH + 4, HOLD);
    step_check();
    start = 1'b0;
    drain();
    abort = 1'b1;
    tick();
    compare("abort_idle", idle_o);
    abort = 1'b0;
    tick();
    compare("abort_stays_idle", idle_o);
`ifdef SISC_SEQ_RETIRE_CNT_EN
    check_retired("retired_abort", 32'd19);
`endif

    // ld_en during RST_WAIT/RUN is ignored; RST_F low mid-run at pc=5
    loop_mode = 1'b0;
    start = 1'b1;
    push_rst();
    push_words(0, 6, 3);
    step_check();
    start = 1'b0;
    ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'hF000_0000;
    drain();
    RST_F = 1'b0;
    ld_en = 1'b0;
    tick();
    compare("midrun_reset", idle_o);
`ifdef SISC_SEQ_RETIRE_CNT_EN
    check_retired("retired_midrun_reset", 32'd0);
`endif
    RST_F = 1'b1;

    // write and start together: HLT lands in word 2 and the run replays
    ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'hF023_0000; start = 1'b1;
    exp_mem[2] = 32'hF023_0000;
    push_rst();
    push_words(0, 3, HOLD);
    push("halted_replay", mk(1'b1, 32'hF023_0000, 1'b0, 4'd2, 1'b1, 1'b0));
    step_check();
    start = 1'b0; ld_en = 1'b0;
    drain();
`ifdef SISC_SEQ_RETIRE_CNT_EN
    check_retired("retired_replay", 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
